led_step_ctrl: RTL and testbench

- Upstream control stage for the LED rotator. Conditions the two active-low push-buttons: 2-FF synchronise, debounce, falling-edge detect.
- Runs a RUN/PAUSE state machine and a direction toggle.
- Generates the one-cycle step strobe and direction bit that the rotator consumes in place of its free-running terminal count.

---
 rtl/led_pkg.sv | 23 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/led_step_ctrl.sv | 104 ++++++++++
 tb/tb_led_step_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED step controller: run state, default
// timing, and the speed-step encoding used when LED_STEP_SPEED_EN is defined.
package led_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } run_state_t;

    // 20 ms debounce and ~148 ms step period at 27 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 540_000;
    localparam int STEP_CYCLES_DEF     = 4_000_000;

    // Speed value is the right-shift applied to the step interval.
    localparam logic [1:0] SPEED_X1 = 2'd0;
    localparam logic [1:0] SPEED_X2 = 2'd1;
    localparam logic [1:0] SPEED_X4 = 2'd2;

    function automatic logic [1:0] next_speed(input logic [1:0] speed);
        return (speed == SPEED_X4) ? SPEED_X1 : speed + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-FF synchroniser, counter-based debounce,
// and a one-cycle registered pulse on each debounced press (stable 1->0).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 540_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          stable;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    // NOTE: sync flops reset to the idle (released) level so that leaving reset
    // never looks like a press; every state flop uses <= so all update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
            press       <= 1'b0;
        end else begin
            sync        <= {sync[0], key_n};
            stable_prev <= stable;
            press       <= stable_prev & ~stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_step_ctrl.sv
// LED rotator control: debounced run/pause and direction keys, RUN/PAUSE FSM,
// step strobe generator. Define LED_STEP_SPEED_EN to add the speed key.
module led_step_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STEP_CYCLES     = STEP_CYCLES_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_run_n,
    input  logic key_dir_n,
`ifdef LED_STEP_SPEED_EN
    input  logic key_speed_n,
`endif
    output logic step,
    output logic dir,
    output logic running
);

    localparam int TW = $clog2(STEP_CYCLES);

    logic          run_press;
    logic          dir_press;
    run_state_t    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] term;
    logic          step_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key_run_n),
        .press (run_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_key (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key_dir_n),
        .press (dir_press)
    );

`ifdef LED_STEP_SPEED_EN
    logic       speed_press;
    logic [1:0] speed_q, speed_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed_key (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .key_n (key_speed_n),
        .press (speed_press)
    );

    assign speed_d = speed_press ? next_speed(speed_q) : speed_q;
    // The new terminal applies on the press cycle itself, so a counter already
    // past it wraps immediately through the >= compare below.
    assign term    = TW'((STEP_CYCLES >> speed_d) - 1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) speed_q <= SPEED_X1;
        else            speed_q <= speed_d;
    end
`else
    assign term = TW'(STEP_CYCLES - 1);
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        step_d  = 1'b0;
        if (run_press) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end
        // A pause press on the terminal cycle wins: the counter holds and the
        // strobe is deferred to the first RUN cycle after resume.
        if (state_q == RUN && !run_press) begin
            if (tick_q >= term) begin
                tick_d = '0;
                step_d = 1'b1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RUN;
            tick_q  <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            running <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            step    <= step_d;
            dir     <= dir ^ dir_press;
            running <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=10.
// Define LED_STEP_SPEED_EN on both RTL and bench to cover the speed key.
module tb_led_step_ctrl;

    localparam int DB = 4;
    localparam int SC = 10;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_run_n = 1'b1;
    logic key_dir_n = 1'b1;
`ifdef LED_STEP_SPEED_EN
    logic key_speed_n = 1'b1;
`endif
    logic step, dir, running;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    led_step_ctrl #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(SC)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_run_n (key_run_n),
        .key_dir_n (key_dir_n),
`ifdef LED_STEP_SPEED_EN
        .key_speed_n (key_speed_n),
`endif
        .step      (step),
        .dir       (dir),
        .running   (running)
    );

    typedef struct {
        logic run_n;
        logic dir_n;
        logic exp_step;
        logic exp_dir;
        logic exp_running;
    } vec_t;

    vec_t tbl[30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge; outputs are sampled there.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    // Leaves the bench 1 ns after "edge 0", with reset just released.
    task automatic do_reset();
        sys_rst_n = 1'b0;
        key_run_n = 1'b1;
        key_dir_n = 1'b1;
`ifdef LED_STEP_SPEED_EN
        key_speed_n = 1'b1;
`endif
        repeat (2) cyc();
        sys_rst_n = 1'b1;
    endtask

`ifdef LED_STEP_SPEED_EN
    task automatic press_speed();
        key_speed_n = 1'b0;
        repeat (8) cyc();
        key_speed_n = 1'b1;
        repeat (8) cyc();
    endtask

    // Measures the distance between two consecutive strobes, bounded.
    task automatic measure_gap(input string name, input int exp_gap);
        int n;
        int gap;
        n = 0;
        while (!step && n < 40) begin cyc(); n++; end
        gap = 0;
        do begin cyc(); gap++; end while (!step && gap < 40);
        check(name, gap, exp_gap);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Free-run cadence with two short run-key glitches that must be rejected.
        for (int i = 0; i < 30; i++) begin
            tbl[i].run_n       = !((i < 3) || (i >= 4 && i < 7));
            tbl[i].dir_n       = 1'b1;
            tbl[i].exp_step    = ((i + 1) % SC == 0);
            tbl[i].exp_dir     = 1'b0;
            tbl[i].exp_running = 1'b1;
        end

        // Reset values while reset is held.
        sys_rst_n = 1'b0;
        repeat (2) cyc();
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_running", running, 1);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            key_run_n = tbl[i].run_n;
            key_dir_n = tbl[i].dir_n;
            cyc();
            check($sformatf("vec%0d_step", i + 1), step, tbl[i].exp_step);
            check($sformatf("vec%0d_dir", i + 1), dir, tbl[i].exp_dir);
            check($sformatf("vec%0d_running", i + 1), running, tbl[i].exp_running);
        end

        // Pause with tick counter at 6 (press raw edge after edge 9), hold 50 cycles, resume.
        do_reset();
        repeat (9) cyc();
        key_run_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 1) check("pre_pause_step", step, 1);
            if (i == 7) check("pause_not_yet", running, 1);
            if (i == 8) check("pause_latency", running, 0);
        end
        key_run_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc();
            check("paused_no_step", step, 0);
            check("paused_running", running, 0);
        end
        key_run_n = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            if (i == 10) key_run_n = 1'b1;
            if (i == 7) check("resume_not_yet", running, 0);
            if (i == 8) check("resume_running", running, 1);
            if (i >= 8 && i <= 11) check("resume_step_low", step, 0);
            if (i == 12) check("resume_first_step", step, 1);
            if (i == 13) check("resume_step_pulse", step, 0);
        end

        // Pause press landing on the terminal-count cycle.
        do_reset();
        repeat (2) cyc();
        key_run_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 7) check("tc_pause_not_yet", running, 1);
            if (i == 8) check("tc_pause_running", running, 0);
            if (i == 8) check("tc_pause_no_step", step, 0);
        end
        key_run_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("tc_paused_no_step", step, 0);
        end
        key_run_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (i == 8) check("tc_resume_running", running, 1);
            if (i == 8) check("tc_resume_step_low", step, 0);
            if (i == 9) check("tc_resume_step", step, 1);
            if (i == 10) check("tc_resume_step_pulse", step, 0);
        end
        key_run_n = 1'b1;

        // Direction toggle leaves the step cadence untouched.
        do_reset();
        key_dir_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 10) key_dir_n = 1'b1;
            check($sformatf("dir_cad%0d_step", i), step, (i % SC) == 0);
            check($sformatf("dir_cad%0d_dir", i), dir, i >= 8);
        end

        // Run and dir pressed on the same cycle.
        do_reset();
        key_run_n = 1'b0;
        key_dir_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 7) check("both_running_before", running, 1);
            if (i == 7) check("both_dir_before", dir, 0);
            if (i == 8) check("both_running", running, 0);
            if (i == 8) check("both_dir", dir, 1);
        end

        // Reset asserted two cycles into a debounce discards the pending press.
        do_reset();
        key_run_n = 1'b0;
        key_dir_n = 1'b0;
        repeat (4) cyc();
        sys_rst_n = 1'b0;
        #1;
        check("midrst_step", step, 0);
        check("midrst_dir", dir, 0);
        check("midrst_running", running, 1);
        key_run_n = 1'b1;
        key_dir_n = 1'b1;
        cyc();
        sys_rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("midrst_after_running", running, 1);
            check("midrst_after_dir", dir, 0);
            check("midrst_after_step", step, (i % SC) == 0);
        end

`ifdef LED_STEP_SPEED_EN
        // Speed press lands with counter=7: immediate wrap and strobe, then interval 5.
        do_reset();
        key_speed_n = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            if (i == 10) key_speed_n = 1'b1;
            if (i >= 7) check($sformatf("spd1_edge%0d_step", i), step,
                              (i == 8) || (i == 13) || (i == 18));
        end
        measure_gap("spd1_gap", 5);
        press_speed();
        measure_gap("spd2_gap", 2);
        press_speed();
        measure_gap("spd0_gap", 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
